// File: rtl/mp_word_divider.sv
// Word-serial multi-precision divider: divides an N-word operand in place by a small
// divisor (MSW first), then optionally adds/subtracts the quotient into an accumulator (LSW first).
module mp_word_divider #(
   parameter int L  = 10,
   parameter int N  = 10,
   parameter int DW = 10,
   localparam int AW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] divisor,
   input  logic          clr_acc,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [L-1:0]  wr_data,
   input  logic          rd_sel,
   input  logic [AW-1:0] rd_addr,
   output logic [L-1:0]  rd_data,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] rem,
   output logic          carry
);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_ACC, S_FIN} state_t;

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t        state_reg, state_next;
   logic [AW-1:0] cnt_reg;
   logic [DW-1:0] d_reg, r_reg;
   logic [1:0]    op_reg;
   logic          c_reg;

   logic [L-1:0]  opr [N];
   logic [L-1:0]  acc [N];
   logic [L-1:0]  opr_next [N];
   logic [L-1:0]  acc_next [N];

   logic          is_idle, bad_start, cnt_last;
   logic [L-1:0]  opr_cur, acc_cur, q_word, acc_word;
   logic [L+DW-1:0] x, x_div;
   logic [DW-1:0] r_new;
   logic [L:0]    sum, diff;
   logic          c_new;

   assign is_idle   = (state_reg == S_IDLE);
   assign bad_start = (divisor == '0) || (op == 2'd3);
   assign cnt_last  = (cnt_reg == LAST);
   assign busy      = !is_idle;
   assign done      = (state_reg == S_FIN);

   // The same word index serves both phases: it counts up in DIV and down in ACC.
   assign opr_cur = opr[cnt_reg];
   assign acc_cur = acc[cnt_reg];

   assign x      = {r_reg, opr_cur};
   assign x_div  = (L+DW)'(d_reg);
   assign q_word = L'(x / x_div);
   assign r_new  = DW'(x % x_div);

   assign sum      = {1'b0, acc_cur} + {1'b0, opr_cur} + (L+1)'(c_reg);
   assign diff     = {1'b0, acc_cur} - {1'b0, opr_cur} - (L+1)'(c_reg);
   assign acc_word = (op_reg == 2'd1) ? sum[L-1:0] : diff[L-1:0];
   assign c_new    = (op_reg == 2'd1) ? sum[L] : diff[L];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_word
         assign opr_next[gi] = (is_idle && wr_en && wr_addr == AW'(gi)) ? wr_data :
                               (state_reg == S_DIV && cnt_reg == AW'(gi)) ? q_word : opr[gi];
         assign acc_next[gi] = (is_idle && clr_acc) ? '0 :
                               (state_reg == S_ACC && cnt_reg == AW'(gi)) ? acc_word : acc[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            opr[i] <= '0;
            acc[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            opr[i] <= opr_next[i];
            acc[i] <= acc_next[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_addr <= LAST) begin
         rd_data <= rd_sel ? acc[rd_addr] : opr[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start) state_next = bad_start ? S_FIN : S_DIV;
         S_DIV:  if (cnt_last) state_next = (op_reg == 2'd0) ? S_FIN : S_ACC;
         S_ACC:  if (cnt_reg == '0) state_next = S_FIN;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
         d_reg   <= '0;
         r_reg   <= '0;
         op_reg  <= '0;
         c_reg   <= 1'b0;
         err     <= 1'b0;
         rem     <= '0;
         carry   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if (bad_start) begin
                     err   <= 1'b1;
                     carry <= 1'b0;
                  end else begin
                     err     <= 1'b0;
                     d_reg   <= divisor;
                     op_reg  <= op;
                     r_reg   <= '0;
                     cnt_reg <= '0;
                  end
               end
            end
            S_DIV: begin
               r_reg <= r_new;
               if (cnt_last) begin
                  rem <= r_new;
                  if (op_reg == 2'd0) begin
                     carry <= 1'b0;
                  end else begin
                     cnt_reg <= LAST;
                     c_reg   <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + AW'(1);
               end
            end
            S_ACC: begin
               c_reg <= c_new;
               if (cnt_reg == '0) begin
                  carry <= c_new;
               end else begin
                  cnt_reg <= cnt_reg - AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_word_divider.sv
// Directed bench for mp_word_divider with L=8, N=4, DW=8; expected values are hand-computed.
module tb_mp_word_divider;

   localparam int L = 8, N = 4, DW = 8, AW = 2;

   logic          clk, rst, start, clr_acc, wr_en, rd_sel;
   logic [1:0]    op;
   logic [DW-1:0] divisor;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [L-1:0]  wr_data, rd_data;
   logic          busy, done, err, carry;
   logic [DW-1:0] rem;

   int errors = 0;
   int checks = 0;

   mp_word_divider #(.L(L), .N(N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .divisor(divisor),
      .clr_acc(clr_acc), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err), .rem(rem), .carry(carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-14s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load(input logic [31:0] words);
      for (int i = 0; i < N; i++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_data = words[31-8*i -: 8];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic clear_acc();
      clr_acc = 1'b1;
      @(negedge clk);
      clr_acc = 1'b0;
   endtask

   task automatic read_arr(input logic sel, output logic [31:0] words);
      words = '0;
      for (int i = 0; i < N; i++) begin
         rd_sel  = sel;
         rd_addr = AW'(i);
         @(negedge clk);
         words[31-8*i -: 8] = rd_data;
      end
   endtask

   task automatic check_arr(input string tag, input logic sel, input logic [31:0] exp);
      logic [31:0] got;
      read_arr(sel, got);
      check(tag, got, exp);
   endtask

   // Starts an operation at a negedge and reports the cycle (after the sampling edge) in which done rose.
   task automatic run_op(input string tag, input logic [1:0] opv, input logic [DW-1:0] dv,
                         input int exp_cycle, input logic meddle);
      int cyc;
      int found;
      start   = 1'b1;
      op      = opv;
      divisor = dv;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         if (meddle && cyc == 2) begin
            start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'hEE; clr_acc = 1'b1;
         end else begin
            start = 1'b0; wr_en = 1'b0; clr_acc = 1'b0;
         end
         if (done) begin
            found = cyc;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0; clr_acc = 1'b0;
      check({tag, "_done"}, found, exp_cycle);
      @(negedge clk);
      check({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   logic [31:0] words;

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; divisor = '0; clr_acc = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_sel = 1'b0; rd_addr = '0;
      repeat (2) @(negedge clk);
      check("rst_outs", {rd_data, busy, done, err, rem, carry}, '0);
      rst = 1'b0;
      @(negedge clk);
      check_arr("rst_opr", 1'b0, 32'h0);

      // Plain division: 0x01000000 / 3
      load(32'h01000000);
      run_op("div3", 2'd0, 8'd3, 5, 1'b0);
      check_arr("div3_opr", 1'b0, 32'h00555555);
      check("div3_rem", rem, 8'h01);
      check("div3_flags", {carry, err}, 2'b00);

      // Accumulate twice
      clear_acc();
      load(32'h01000000);
      run_op("add1", 2'd1, 8'd3, 9, 1'b0);
      check_arr("add1_acc", 1'b1, 32'h00555555);
      load(32'h01000000);
      run_op("add2", 2'd1, 8'd3, 9, 1'b0);
      check_arr("add2_acc", 1'b1, 32'h00AAAAAA);
      check("add2_carry", carry, 1'b0);
      check("add2_rem", rem, 8'h01);

      // Subtract from zero: borrows all the way out
      clear_acc();
      load(32'h01000000);
      run_op("sub", 2'd2, 8'd3, 9, 1'b0);
      check_arr("sub_acc", 1'b1, 32'hFFAAAAAB);
      check("sub_carry", carry, 1'b1);

      // Error starts leave storage and rem alone and clear carry
      load(32'h12345678);
      run_op("dzero", 2'd1, 8'd0, 1, 1'b0);
      check("dzero_err", err, 1'b1);
      check("dzero_carry", carry, 1'b0);
      check("dzero_rem", rem, 8'h01);
      check_arr("dzero_opr", 1'b0, 32'h12345678);
      check_arr("dzero_acc", 1'b1, 32'hFFAAAAAB);
      run_op("op3", 2'd3, 8'd3, 1, 1'b0);
      check("op3_err", err, 1'b1);
      check_arr("op3_opr", 1'b0, 32'h12345678);
      run_op("div1a", 2'd0, 8'd1, 5, 1'b0);
      check("div1a_err", err, 1'b0);
      check_arr("div1a_opr", 1'b0, 32'h12345678);

      // Divisor extremes
      load(32'hFFFFFFFF);
      run_op("div1", 2'd0, 8'd1, 5, 1'b0);
      check_arr("div1_opr", 1'b0, 32'hFFFFFFFF);
      check("div1_rem", rem, 8'h00);
      run_op("divff", 2'd0, 8'hFF, 5, 1'b0);
      check_arr("divff_opr", 1'b0, 32'h01010101);
      check("divff_rem", rem, 8'h00);

      // Host writes, clr_acc and start while busy are ignored; add wraps with carry out
      load(32'h01000000);
      run_op("busy", 2'd1, 8'd3, 9, 1'b1);
      check_arr("busy_opr", 1'b0, 32'h00555555);
      check_arr("busy_acc", 1'b1, 32'h00000000);
      check("busy_carry", carry, 1'b1);

      // Asynchronous reset in the middle of DIV
      load(32'h87654321);
      start = 1'b1; op = 2'd1; divisor = 8'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_outs", {rd_data, busy, done, err, rem, carry}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_idle", {busy, done}, 2'b00);
      check_arr("mid_opr", 1'b0, 32'h0);
      check_arr("mid_acc", 1'b1, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
